// File: rtl/morse_char_sequencer.sv
// Turns dot/dash/gap pulses into ASCII characters (plus word spaces) queued in a small FIFO.
// Latency: char visible 1 cycle after its gap, space 1 cycle later; backpressure: out_ready stalls the head, a push into a full FIFO is dropped and sets overflow.
module morse_char_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dot,
    input  logic       dash,
    input  logic       lg,
    input  logic       wg,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow,
    output logic       pending
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {COLLECT, SPACE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      len_q, len_d;
    logic [4:0]      pat_q, pat_d;
    logic            csp_q, csp_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            elem;
    logic            close;
    logic            push;
    logic            push_ok;
    logic            pop;
    logic            full;
    logic [7:0]      push_dat;
    logic [7:0]      sym_char;

    // Unused upper pattern bits are always zero while len <= 5, so the full byte can be matched.
    always_comb begin
        sym_char = 8'h3F;
        case ({len_q, pat_q})
            8'b001_00000: sym_char = 8'h45; // E
            8'b001_00001: sym_char = 8'h54; // T
            8'b010_00001: sym_char = 8'h41; // A
            8'b010_00000: sym_char = 8'h49; // I
            8'b010_00011: sym_char = 8'h4D; // M
            8'b010_00010: sym_char = 8'h4E; // N
            8'b011_00100: sym_char = 8'h44; // D
            8'b011_00110: sym_char = 8'h47; // G
            8'b011_00101: sym_char = 8'h4B; // K
            8'b011_00111: sym_char = 8'h4F; // O
            8'b011_00010: sym_char = 8'h52; // R
            8'b011_00000: sym_char = 8'h53; // S
            8'b011_00001: sym_char = 8'h55; // U
            8'b011_00011: sym_char = 8'h57; // W
            8'b100_01000: sym_char = 8'h42; // B
            8'b100_01010: sym_char = 8'h43; // C
            8'b100_00010: sym_char = 8'h46; // F
            8'b100_00000: sym_char = 8'h48; // H
            8'b100_00111: sym_char = 8'h4A; // J
            8'b100_00100: sym_char = 8'h4C; // L
            8'b100_00110: sym_char = 8'h50; // P
            8'b100_01101: sym_char = 8'h51; // Q
            8'b100_00001: sym_char = 8'h56; // V
            8'b100_01001: sym_char = 8'h58; // X
            8'b100_01011: sym_char = 8'h59; // Y
            8'b100_01100: sym_char = 8'h5A; // Z
            8'b101_11111: sym_char = 8'h30;
            8'b101_01111: sym_char = 8'h31;
            8'b101_00111: sym_char = 8'h32;
            8'b101_00011: sym_char = 8'h33;
            8'b101_00001: sym_char = 8'h34;
            8'b101_00000: sym_char = 8'h35;
            8'b101_10000: sym_char = 8'h36;
            8'b101_11000: sym_char = 8'h37;
            8'b101_11100: sym_char = 8'h38;
            8'b101_11110: sym_char = 8'h39;
            default:      sym_char = 8'h3F;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        pat_d    = pat_q;
        csp_d    = csp_q;
        push     = 1'b0;
        push_dat = sym_char;
        close    = 1'b0;
        elem     = dot | dash;

        case (state_q)
            COLLECT: begin
                if (wg && len_q != 3'd0) begin
                    push    = 1'b1;
                    close   = 1'b1;
                    state_d = SPACE;
                end else if (lg && len_q != 3'd0) begin
                    push  = 1'b1;
                    close = 1'b1;
                    csp_d = 1'b1;
                end else if (wg && csp_q) begin
                    push     = 1'b1;
                    push_dat = 8'h20;
                    csp_d    = 1'b0;
                end
            end
            SPACE: begin
                push     = 1'b1;
                push_dat = 8'h20;
                csp_d    = 1'b0;
                state_d  = COLLECT;
            end
            default: state_d = COLLECT;
        endcase

        // A gap closes the old symbol first; a coincident element starts the new one.
        if (close) begin
            len_d = elem ? 3'd1 : 3'd0;
            pat_d = {4'b0000, dash};
        end else if (elem) begin
            len_d = (len_q == 3'd6) ? 3'd6 : len_q + 3'd1;
            pat_d = {pat_q[3:0], dash};
        end
    end

    always_comb begin
        full     = (count_q == CW'(FIFO_DEPTH));
        out_valid = (count_q != '0);
        pop      = out_valid & out_ready;
        push_ok  = push & (~full | pop);
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
        end
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        ovf_d    = ovf_q | (push & ~push_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= COLLECT;
            len_q    <= '0;
            pat_q    <= '0;
            csp_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            pat_q    <= pat_d;
            csp_q    <= csp_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign out_data = mem_q[rd_ptr_q];
    assign overflow = ovf_q;
    assign pending  = (len_q != 3'd0);

endmodule

// File: tb/tb_morse_char_sequencer.sv
// Directed vector table plus randomized run against a string-based Morse reference model.
module tb_morse_char_sequencer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dot = 1'b0, dash = 1'b0, lg = 1'b0, wg = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid, overflow, pending;

    int checks = 0;
    int errors = 0;

    morse_char_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .dot(dot), .dash(dash), .lg(lg), .wg(wg),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, dt, ds, l, w, rdy;
        logic       e_vld;
        logic [7:0] e_dat;
        logic       e_ovf, e_pend;
    } vec_t;

    vec_t vecs[$];

    // Reference model: the symbol is kept as a string of '.'/'-' and looked up by name.
    string codes [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                          "-----", ".----", "..---", "...--", "....-", ".....",
                          "-....", "--...", "---..", "----."};
    string      sym = "";
    bit         space_due = 0, csp = 0, m_ovf = 0;
    logic [7:0] mq[$];

    function automatic logic [7:0] xlate(string s);
        if (s.len() > 5) return 8'h3F;
        for (int i = 0; i < 36; i++) begin
            if (codes[i] == s) return (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
        end
        return 8'h3F;
    endfunction

    task automatic model_step();
        logic [7:0] pc;
        bit do_push, do_pop;
        if (reset) begin
            sym = ""; space_due = 0; csp = 0; m_ovf = 0; mq.delete();
            return;
        end
        pc = 8'h00;
        do_push = 0;
        do_pop = (mq.size() > 0) && out_ready;
        if (space_due) begin
            do_push = 1; pc = 8'h20; csp = 0; space_due = 0;
        end else if (wg && sym.len() > 0) begin
            do_push = 1; pc = xlate(sym); sym = ""; space_due = 1;
        end else if (lg && sym.len() > 0) begin
            do_push = 1; pc = xlate(sym); sym = ""; csp = 1;
        end else if (wg && csp) begin
            do_push = 1; pc = 8'h20; csp = 0;
        end
        if (dot || dash) sym = {sym, dash ? "-" : "."};
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            if (mq.size() < DEPTH) mq.push_back(pc);
            else m_ovf = 1;
        end
    endtask

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(string tag);
        check({tag, " model out_valid"}, 8'(out_valid), 8'(mq.size() > 0));
        if (mq.size() > 0) check({tag, " model out_data"}, out_data, mq[0]);
        check({tag, " model overflow"}, 8'(overflow), 8'(m_ovf));
        check({tag, " model pending"}, 8'(pending), 8'(sym.len() > 0));
    endtask

    task automatic tick(input logic r, input logic d, input logic s,
                        input logic l, input logic w, input logic rd);
        reset = r; dot = d; dash = s; lg = l; wg = w; out_ready = rd;
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic void add(logic r, logic d, logic s, logic l, logic w, logic rd,
                                logic vld, logic [7:0] dat, logic ovf, logic pnd);
        vec_t v;
        v.rst = r; v.dt = d; v.ds = s; v.l = l; v.w = w; v.rdy = rd;
        v.e_vld = vld; v.e_dat = dat; v.e_ovf = ovf; v.e_pend = pnd;
        vecs.push_back(v);
    endfunction

    initial begin
        // Reset, then A and digit 0
        add(1,0,0,0,0,1, 0,8'h00,0,0);
        add(0,1,0,0,0,1, 0,8'h00,0,1);
        add(0,0,1,0,0,1, 0,8'h00,0,1);
        add(0,0,0,1,0,1, 1,8'h41,0,0);
        add(0,0,0,0,0,1, 0,8'h00,0,0);
        for (int i = 0; i < 5; i++) add(0,0,1,0,0,1, 0,8'h00,0,1);
        add(0,0,0,1,0,1, 1,8'h30,0,0);
        add(0,0,0,0,0,1, 0,8'h00,0,0);
        // S then word gap: letter and space on consecutive cycles, second wg adds nothing
        for (int i = 0; i < 3; i++) add(0,1,0,0,0,1, 0,8'h00,0,1);
        add(0,0,0,0,1,1, 1,8'h53,0,0);
        add(0,0,0,0,0,1, 1,8'h20,0,0);
        add(0,0,0,0,0,1, 0,8'h00,0,0);
        add(0,0,0,0,1,1, 0,8'h00,0,0);
        add(0,0,0,0,0,1, 0,8'h00,0,0);
        // Word gap right after reset queues nothing
        add(1,0,0,0,0,1, 0,8'h00,0,0);
        add(0,0,0,0,1,1, 0,8'h00,0,0);
        add(0,0,0,0,0,1, 0,8'h00,0,0);
        // Too long, and unmapped ..--
        for (int i = 0; i < 7; i++) add(0,1,0,0,0,1, 0,8'h00,0,1);
        add(0,0,0,1,0,1, 1,8'h3F,0,0);
        add(0,0,0,0,0,1, 0,8'h00,0,0);
        add(0,1,0,0,0,1, 0,8'h00,0,1);
        add(0,1,0,0,0,1, 0,8'h00,0,1);
        add(0,0,1,0,0,1, 0,8'h00,0,1);
        add(0,0,1,0,0,1, 0,8'h00,0,1);
        add(0,0,0,1,0,1, 1,8'h3F,0,0);
        add(0,0,0,0,0,1, 0,8'h00,0,0);
        // Gap and element in one cycle: E closes, dash starts T
        add(0,1,0,0,0,1, 0,8'h00,0,1);
        add(0,0,1,1,0,1, 1,8'h45,0,1);
        add(0,0,0,1,0,1, 1,8'h54,0,0);
        add(0,0,0,0,0,1, 0,8'h00,0,0);
        // E, letter gap, then word gap pushes the space directly
        add(0,1,0,0,0,1, 0,8'h00,0,1);
        add(0,0,0,1,0,1, 1,8'h45,0,0);
        add(0,0,0,0,1,1, 1,8'h20,0,0);
        add(0,0,0,0,0,1, 0,8'h00,0,0);
        // Fill with E T E T while stalled, fifth letter dropped
        for (int i = 0; i < 2; i++) begin
            add(0,1,0,0,0,0, i > 0,8'h45,0,1);
            add(0,0,0,1,0,0, 1,8'h45,0,0);
            add(0,0,1,0,0,0, 1,8'h45,0,1);
            add(0,0,0,1,0,0, 1,8'h45,0,0);
        end
        add(0,1,0,0,0,0, 1,8'h45,0,1);
        add(0,0,0,1,0,0, 1,8'h45,1,0);
        // Full with simultaneous pop and push, then drain T E T T
        add(0,0,1,0,0,0, 1,8'h45,1,1);
        add(0,0,0,1,0,1, 1,8'h54,1,0);
        add(0,0,0,0,0,1, 1,8'h45,1,0);
        add(0,0,0,0,0,1, 1,8'h54,1,0);
        add(0,0,0,0,0,1, 1,8'h54,1,0);
        add(0,0,0,0,0,1, 0,8'h00,1,0);
        for (int i = 0; i < 4; i++) begin
            add(0,1,0,0,0,1, 0,8'h00,1,1);
            add(0,0,0,1,0,1, 1,8'h45,1,0);
        end
        add(0,0,0,0,0,1, 0,8'h00,1,0);
        // Reset with two queued entries and a half-built symbol
        add(0,1,0,0,0,0, 0,8'h00,1,1);
        add(0,0,0,1,0,0, 1,8'h45,1,0);
        add(0,0,1,0,0,0, 1,8'h45,1,1);
        add(0,0,0,1,0,0, 1,8'h45,1,0);
        add(0,1,0,0,0,0, 1,8'h45,1,1);
        add(0,0,1,0,0,0, 1,8'h45,1,1);
        add(1,0,0,0,0,0, 0,8'h00,0,0);
        add(0,1,0,0,0,1, 0,8'h00,0,1);
        add(0,0,0,1,0,1, 1,8'h45,0,0);
        add(0,0,0,0,0,1, 0,8'h00,0,0);

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].dt, vecs[i].ds, vecs[i].l, vecs[i].w, vecs[i].rdy);
            check($sformatf("vec%0d out_valid", i), 8'(out_valid), 8'(vecs[i].e_vld));
            if (vecs[i].e_vld || vecs[i].rst)
                check($sformatf("vec%0d out_data", i), out_data, vecs[i].e_dat);
            check($sformatf("vec%0d overflow", i), 8'(overflow), 8'(vecs[i].e_ovf));
            check($sformatf("vec%0d pending", i), 8'(pending), 8'(vecs[i].e_pend));
            check_model($sformatf("vec%0d", i));
        end

        tick(1,0,0,0,0,1);
        check_model("rand reset");
        for (int c = 0; c < 4000; c++) begin
            tick($urandom_range(0, 599) == 0,
                 ($urandom % 100) < 30, ($urandom % 100) < 25,
                 ($urandom % 100) < 12, ($urandom % 100) < 6,
                 ($urandom % 100) < 55);
            check_model($sformatf("rand%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
